// File: rtl/debounce_step_gen.sv
// Push-button conditioner: 2-FF synchronizer plus debounce FSM producing one-cycle step pulses.
// Optional auto-repeat while held is enabled by defining AUTO_REPEAT_EN.
module debounce_step_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_state,
  output logic press_pulse,
  output logic release_pulse
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             btn_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_state_q, btn_state_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic             accept_press, accept_release;
  logic             rpt_fire;

  // sync_q[0] is the metastability catcher; only sync_q[1] is seen by the FSM.
  always_comb begin
    sync_d = {sync_q[0], btn_in};
  end

  assign btn_s = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q          <= 2'b00;
      state_q         <= IDLE;
      cnt_q           <= '0;
      btn_state_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      sync_q          <= sync_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      btn_state_q     <= btn_state_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
    end
  end

  // The debounce counter only advances while below DEB_LAST, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = WAIT_PRESS;
          cnt_d   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = WAIT_RELEASE;
          cnt_d   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (btn_s) begin
          state_d = PRESSED;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    accept_press    = (state_q == WAIT_PRESS) && btn_s && (cnt_q == DEB_LAST);
    accept_release  = (state_q == WAIT_RELEASE) && !btn_s && (cnt_q == DEB_LAST);
    btn_state_d     = (state_d == PRESSED) || (state_d == WAIT_RELEASE);
    press_pulse_d   = accept_press | rpt_fire;
    release_pulse_d = accept_release;
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_armed_q, rpt_armed_d;
  logic [CNT_W-1:0] rpt_target;

  // Timer runs only in PRESSED, so a release bounce freezes it rather than restarting it.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_armed_d = rpt_armed_q;
    rpt_fire    = 1'b0;
    rpt_target  = rpt_armed_q ? RPT_NEXT : RPT_FIRST;
    if (state_q == PRESSED) begin
      if (rpt_cnt_q == rpt_target) begin
        rpt_fire    = 1'b1;
        rpt_cnt_d   = '0;
        rpt_armed_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + CNT_ONE;
      end
    end
    if (state_d == IDLE) begin
      rpt_cnt_d   = '0;
      rpt_armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign btn_state     = btn_state_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;

endmodule

// File: tb/tb_debounce_step_gen.sv
// Scoreboard bench for debounce_step_gen: expected pulses are queued with their cycle when stimulus is driven.
module tb_debounce_step_gen;

  localparam int DEB = 4;
  localparam int RD  = 8;
  localparam int RP  = 4;
  localparam int LAT = DEB + 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_in = 1'b0;
  logic btn_state, press_pulse, release_pulse;

  debounce_step_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(16),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .btn_state(btn_state),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int exp_kind[$];
  int exp_cyc[$];
  int mon_k, mon_c;

  task automatic expect_pulse(input int kind, input int at);
    exp_kind.push_back(kind);
    exp_cyc.push_back(at);
  endtask

  always @(negedge clk) begin
    if (exp_cyc.size() > 0 && exp_cyc[0] < cyc) begin
      mon_k = exp_kind.pop_front();
      mon_c = exp_cyc.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_pulse kind=%0d got none by cyc=%0d want at cyc=%0d", mon_k, cyc, mon_c);
    end
    if (press_pulse && release_pulse) begin
      checks++;
      errors++;
      $display("FAIL both_pulses cyc=%0d got press=1 release=1 want at most one", cyc);
    end
    if (press_pulse || release_pulse) begin
      checks++;
      if (exp_kind.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got press=%0b release=%0b want none", cyc, press_pulse, release_pulse);
      end else begin
        mon_k = exp_kind.pop_front();
        mon_c = exp_cyc.pop_front();
        if (mon_k != (release_pulse ? 1 : 0) || mon_c != cyc) begin
          errors++;
          $display("FAIL pulse_match got kind=%0d cyc=%0d want kind=%0d cyc=%0d",
                   release_pulse ? 1 : 0, cyc, mon_k, mon_c);
        end
      end
    end
  end

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_kind.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_kind.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending pulses want 0", name, exp_kind.size());
      exp_kind.delete();
      exp_cyc.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_in = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if ({btn_state, press_pulse, release_pulse} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs got %b want 000", {btn_state, press_pulse, release_pulse});
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (btn_state !== 1'b0) begin
      errors++;
      $display("FAIL idle_btn_state got %b want 0", btn_state);
    end
  endtask

  task automatic test_press_release();
    int n;
    n = cyc;
    btn_in = 1'b1;
    expect_pulse(0, n + LAT);
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (btn_state !== 1'b0) begin
      errors++;
      $display("FAIL press_btn_state_early got %b want 0", btn_state);
    end
    @(negedge clk);
    checks++;
    if (btn_state !== 1'b1) begin
      errors++;
      $display("FAIL press_btn_state_accept got %b want 1", btn_state);
    end
    repeat (30 - LAT) @(negedge clk);
    n = cyc;
    btn_in = 1'b0;
    expect_pulse(1, n + LAT);
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (btn_state !== 1'b1) begin
      errors++;
      $display("FAIL release_btn_state_early got %b want 1", btn_state);
    end
    @(negedge clk);
    checks++;
    if (btn_state !== 1'b0) begin
      errors++;
      $display("FAIL release_btn_state_accept got %b want 0", btn_state);
    end
    drain("press_release", 20);
  endtask

  task automatic test_bounce();
    bit seen_high;
    int n;
    seen_high = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn_in = ~btn_in;
      repeat (2) begin
        @(negedge clk);
        if (btn_state) seen_high = 1'b1;
      end
    end
    btn_in = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (btn_state) seen_high = 1'b1;
    end
    checks++;
    if (seen_high) begin
      errors++;
      $display("FAIL bounce_btn_state got 1 want 0");
    end
    // A high run of exactly DEB cycles must be rejected.
    btn_in = 1'b1;
    repeat (DEB) @(negedge clk);
    btn_in = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (btn_state !== 1'b0) begin
      errors++;
      $display("FAIL short_press_btn_state got %b want 0", btn_state);
    end
    // One cycle longer is accepted.
    n = cyc;
    btn_in = 1'b1;
    expect_pulse(0, n + LAT);
    repeat (DEB + 1) @(negedge clk);
    btn_in = 1'b0;
    expect_pulse(1, cyc + LAT);
    drain("min_press", 30);
  endtask

  task automatic test_glitch();
    bit seen_low;
    int n;
    n = cyc;
    btn_in = 1'b1;
    expect_pulse(0, n + LAT);
    drain("glitch_accept", 20);
    repeat (5) @(negedge clk);
    seen_low = 1'b0;
    btn_in = 1'b0;
    repeat (2) @(negedge clk);
    btn_in = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (!btn_state) seen_low = 1'b1;
    end
    btn_in = 1'b0;
    repeat (DEB) @(negedge clk);
    btn_in = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (!btn_state) seen_low = 1'b1;
    end
    checks++;
    if (seen_low) begin
      errors++;
      $display("FAIL glitch_btn_state got 0 want 1");
    end
    n = cyc;
    btn_in = 1'b0;
    expect_pulse(1, n + LAT);
    drain("glitch_release", 20);
  endtask

  task automatic test_reset_mid();
    int n;
    n = cyc;
    btn_in = 1'b1;
    while (cyc < n + 5) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({btn_state, press_pulse, release_pulse} !== 3'b000) begin
      errors++;
      $display("FAIL reset_wait_press got %b want 000", {btn_state, press_pulse, release_pulse});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = cyc;
    expect_pulse(0, n + LAT);
    drain("reset_repress", 20);
    checks++;
    if (btn_state !== 1'b1) begin
      errors++;
      $display("FAIL reset_repress_btn_state got %b want 1", btn_state);
    end
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (btn_state !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_drop got %b want 0", btn_state);
    end
    @(negedge clk);
    reset = 1'b0;
    n = cyc;
    expect_pulse(0, n + LAT);
    drain("reset_pressed", 20);
    n = cyc;
    btn_in = 1'b0;
    expect_pulse(1, n + LAT);
    drain("reset_release", 20);
  endtask

  task automatic test_auto_repeat();
    int n, a;
    n = cyc;
    a = n + LAT;
    btn_in = 1'b1;
    expect_pulse(0, a);
`ifdef AUTO_REPEAT_EN
    for (int t = RD; t <= 28; t += RP) expect_pulse(0, a + t);
`endif
    while (cyc < a + 27) @(negedge clk);
    n = cyc;
    btn_in = 1'b0;
    expect_pulse(1, n + LAT);
    drain("auto_repeat", 30);
    checks++;
    if (btn_state !== 1'b0) begin
      errors++;
      $display("FAIL auto_repeat_btn_state got %b want 0", btn_state);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_press_release();
    test_bounce();
    test_glitch();
    test_reset_mid();
    test_auto_repeat();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
